feature_mem_arbiter: RTL and testbench
======================================

FEATURE_MEM_ARBITER -- requirements
Module: feature_mem_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (0 instruction fetch, 1 operand read, 2 result writeback).
REQ-002 Parameter AW, default 12, feature-memory address width (4096 words).
REQ-003 Parameter DW, default 32, data width.
REQ-004 Parameter MAX_BURST, default 16, maximum consecutive locked beats for one owner.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req  in  NREQ  per-requester beat request, held until gnt.
REQ-008 lock  in  NREQ  request to keep ownership after this beat.
REQ-009 we  in  NREQ  1 = write beat, 0 = read beat.
REQ-010 addr  in  NREQ*AW  packed per-requester addresses, slice i = requester i.
REQ-011 wdata  in  NREQ*DW  packed per-requester write data.
REQ-012 gnt  out  NREQ  combinational accept; beat captured at the edge ending a cycle with req[i]&gnt[i].
REQ-013 rvalid  out  NREQ  one-cycle pulse, read data for requester i on rdata.
REQ-014 rdata  out  DW  registered read data.
REQ-015 feature_addr  out  AW  registered memory address.
REQ-016 feature_data  out  DW  registered memory write data.
REQ-017 feature_mem_en  out  1  registered memory write enable (memory writes on rising edge when high).
REQ-018 feature_idata  in  DW  memory read data, valid in the cycle after feature_addr is presented.
REQ-019 busy  out  1  high while any beat is in flight or an owner holds lock.

Function
REQ-020 gnt SHALL be one-hot or zero; at most one beat accepted per cycle.
REQ-021 States: IDLE (no owner) and OWN (owner index held); OWN entered when an accepted beat has lock=1.
REQ-022 In IDLE, winner SHALL be the first asserted req searching from round-robin pointer ptr upward, wrapping NREQ-1 -> 0.
REQ-023 In OWN, only the owner SHALL receive gnt; others see gnt=0 regardless of req.
REQ-024 OWN -> IDLE when: owner's accepted beat has lock=0; owner has req=0 for one cycle; or burst counter reaches MAX_BURST (forced release on that beat, regardless of lock).
REQ-025 On every transition to IDLE, and on every non-locked accept in IDLE, ptr SHALL become winner+1 mod NREQ.
REQ-026 Burst counter SHALL count accepted beats of the current owner, starting at 1, and clear on entering IDLE.
REQ-027 Accepted beat at edge N: feature_addr/feature_data/feature_mem_en updated at edge N (visible cycle N+1); feature_mem_en=we of the beat; cycles without an accept drive feature_mem_en=0, addr/data hold.
REQ-028 Read latency: accept edge N -> rdata=feature_idata captured at edge N+1, rvalid[i] high in cycle N+2 only.
REQ-029 Back-to-back reads SHALL sustain one beat per cycle; a read after a write to the same address SHALL return the new data.
REQ-030 busy SHALL be req-independent: high if state=OWN or any read pending in the 2-cycle pipeline.

Reset
REQ-031 On reset low, asynchronously: state=IDLE, ptr=0, burst counter=0, gnt internal=0, rvalid=0, rdata=0, feature_addr=0, feature_data=0, feature_mem_en=0, busy=0.
REQ-032 Reset mid-burst or with reads in flight SHALL discard them; no rvalid after reset release for pre-reset beats.

Structure
REQ-033 Package feature_arb_pkg SHALL hold NREQ/AW/DW/MAX_BURST defaults and the IDLE/OWN state enum.
REQ-034 Sub-module rr_priority_picker (req vector, ptr -> one-hot winner) SHALL implement REQ-022.

Verification
REQ-035 req=3'b111, lock=0, all reads, addrs 10/20/30 -> gnt order 0,1,2,0; rvalid order 0,1,2 each 2 cycles after accept.
REQ-036 Requester 2 writes 0xDEADBEEF to 0x0FF, then requester 1 reads 0x0FF -> feature_mem_en high one cycle, rdata=0xDEADBEEF.
REQ-037 Requester 1 lock=1 for 20 beats, req 0 and 2 asserted -> forced release after beat 16, next gnt to requester 2.
REQ-038 Owner 0 locked drops req one cycle -> IDLE, requester 1 granted next cycle.
REQ-039 reset low during locked burst with 2 reads in flight -> all outputs 0 immediately, no rvalid afterwards, ptr=0.

Source files
------------

// File: rtl/feature_arb_pkg.sv
// Shared defaults, state encoding and index helper for the feature-memory arbiter.
package feature_arb_pkg;

    localparam int unsigned NREQ_DEF      = 3;
    localparam int unsigned AW_DEF        = 12;
    localparam int unsigned DW_DEF        = 32;
    localparam int unsigned MAX_BURST_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping to 0.
module rr_priority_picker #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx
);

    int unsigned best_d;
    int unsigned d;

    // Smallest circular distance from ptr wins; ties impossible since distances are unique.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        best_d  = NREQ;
        d       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            d = (i >= 32'(ptr)) ? i - 32'(ptr) : i + NREQ - 32'(ptr);
            if (req[i] && d < best_d) begin
                best_d    = d;
                win_idx   = PW'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/feature_mem_arbiter.sv
// Round-robin arbiter with locked bursts in front of a single-port feature memory.
module feature_mem_arbiter
    import feature_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        feature_addr,
    output logic [DW-1:0]        feature_data,
    output logic                 feature_mem_en,
    input  logic [DW-1:0]        feature_idata,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t      state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   burst_inc;
    logic [NREQ-1:0] rd_pend;
    logic [NREQ-1:0] pick_oh;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   sel_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_lock;
    logic            sel_we;
    logic            accept;

    rr_priority_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    always_comb begin
        gnt = '0;
        if (reset) begin
            if (state == IDLE) begin
                gnt = pick_oh;
            end else begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (owner == PW'(i)) gnt[i] = req[i];
                end
            end
        end
    end

    always_comb begin
        sel_idx   = (state == OWN) ? owner : pick_idx;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_lock  = 1'b0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
                sel_lock  = lock[i];
                sel_we    = we[i];
            end
        end
    end

    assign accept    = |gnt;
    assign burst_inc = burst_cnt + 1'b1;
    assign busy      = (state == OWN) | (|rd_pend) | (|rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= '0;
            ptr            <= '0;
            burst_cnt      <= '0;
            rd_pend        <= '0;
            rvalid         <= '0;
            rdata          <= '0;
            feature_addr   <= '0;
            feature_data   <= '0;
            feature_mem_en <= 1'b0;
        end else begin
            feature_mem_en <= 1'b0;
            rd_pend        <= gnt & ~we;
            rvalid         <= rd_pend;
            if (|rd_pend) rdata <= feature_idata;
            if (accept) begin
                feature_addr   <= sel_addr;
                feature_data   <= sel_wdata;
                feature_mem_en <= sel_we;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_lock && MAX_BURST > 1) begin
                            state     <= OWN;
                            owner     <= sel_idx;
                            burst_cnt <= CW'(1);
                        end else begin
                            ptr <= PW'(wrap_inc(32'(sel_idx), NREQ));
                        end
                    end
                end
                OWN: begin
                    // No accept here means the owner dropped req this cycle.
                    if (!accept || !sel_lock || burst_inc == CW'(MAX_BURST)) begin
                        state     <= IDLE;
                        ptr       <= PW'(wrap_inc(32'(owner), NREQ));
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_mem_arbiter.sv
// Randomized and directed bench for feature_mem_arbiter against a transaction-level model.
module tb_feature_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MAXB = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req, lock, we, gnt, rvalid;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]      rdata, feature_data, feature_idata;
    logic [AW-1:0]      feature_addr;
    logic               feature_mem_en, busy;

    logic [DW-1:0] mem    [4096];
    logic [DW-1:0] shadow [4096];

    typedef struct {
        int            c;
        int            idx;
        logic [DW-1:0] d;
    } rd_t;
    rd_t rdq[$];

    int            n_total = 0;
    int            n_bad   = 0;
    int            cyc     = 0;
    int            m_owner, m_ptr, m_cnt;
    logic          exp_men;
    logic [AW-1:0] exp_faddr;
    logic [DW-1:0] exp_fdata, exp_rdata;
    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] seq [32];

    feature_mem_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAXB)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .req            (req),
        .lock           (lock),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .feature_addr   (feature_addr),
        .feature_data   (feature_data),
        .feature_mem_en (feature_mem_en),
        .feature_idata  (feature_idata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (feature_mem_en) mem[feature_addr] <= feature_data;
    assign feature_idata = mem[feature_addr];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        rdq.delete();
        exp_men   = 1'b0;
        exp_faddr = '0;
        exp_fdata = '0;
        exp_rdata = '0;
    endtask

    task automatic set_req(input int i, input logic r, input logic l, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]             = r;
        lock[i]            = l;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_cnt   = 0;
    endtask

    // Registered outputs: reads return two cycles after their accept cycle.
    task automatic check_outputs();
        logic [NREQ-1:0] exp_rv;
        exp_rv = '0;
        while (rdq.size() > 0 && rdq[0].c < cyc - 2) void'(rdq.pop_front());
        if (rdq.size() > 0 && rdq[0].c == cyc - 2) begin
            exp_rv[rdq[0].idx] = 1'b1;
            exp_rdata          = rdq[0].d;
        end
        check_eq("rvalid", rvalid, exp_rv);
        check_eq("rdata", rdata, exp_rdata);
        check_eq("mem_en", feature_mem_en, exp_men);
        check_eq("faddr", feature_addr, exp_faddr);
        check_eq("fdata", feature_data, exp_fdata);
        check_eq("busy", busy, (m_owner >= 0) || (rdq.size() > 0));
    endtask

    // Entered at posedge+1 with this cycle's inputs already driven.
    task automatic run_cycle();
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   a;
        int              g;
        #1;
        eg = '0;
        g  = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (req[i] && g < 0) g = i;
            end
        end else if (req[m_owner]) begin
            g = m_owner;
        end
        if (g >= 0) eg[g] = 1'b1;
        check_eq("gnt", gnt, eg);
        last_gnt = gnt;

        exp_men = 1'b0;
        if (g >= 0) begin
            a         = addr[g*AW +: AW];
            exp_faddr = a;
            exp_fdata = wdata[g*DW +: DW];
            if (we[g]) begin
                exp_men   = 1'b1;
                shadow[a] = wdata[g*DW +: DW];
            end else begin
                rdq.push_back('{c: cyc, idx: g, d: shadow[a]});
            end
            if (m_owner < 0) begin
                if (lock[g] && MAXB > 1) begin
                    m_owner = g;
                    m_cnt   = 1;
                end else begin
                    m_ptr = (g + 1) % NREQ;
                end
            end else begin
                m_cnt++;
                if (!lock[g] || m_cnt == MAXB) model_release();
            end
        end else if (m_owner >= 0) begin
            model_release();
        end

        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    initial begin
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        last_gnt = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check_eq("rst_gnt_init", gnt, 0);
        rst_n = 1'b1;

        // Three readers, no lock: strict rotation.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(10 * (i + 1)), '0);
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            seq[c] = last_gnt;
        end
        check_eq("rr_0", seq[0], 3'b001);
        check_eq("rr_1", seq[1], 3'b010);
        check_eq("rr_2", seq[2], 3'b100);
        check_eq("rr_3", seq[3], 3'b001);
        idle(3);

        // Write then read back the same address.
        set_req(2, 1'b1, 1'b0, 1'b1, 12'h0FF, 32'hDEADBEEF);
        run_cycle();
        req = '0;
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h0FF, '0);
        run_cycle();
        req = '0;
        run_cycle();
        check_eq("raw_rvalid", rvalid, 3'b010);
        check_eq("raw_rdata", rdata, 32'hDEADBEEF);
        idle(3);

        // Locked burst longer than MAX_BURST with competing requesters.
        set_req(1, 1'b1, 1'b1, 1'b0, 12'h020, '0);
        run_cycle();
        seq[0] = last_gnt;
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h001, '0);
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h002, '0);
        for (int c = 1; c < 20; c++) begin
            run_cycle();
            seq[c] = last_gnt;
        end
        check_eq("burst_first", seq[0], 3'b010);
        check_eq("burst_16th", seq[15], 3'b010);
        check_eq("burst_release", seq[16], 3'b100);
        idle(3);

        // Owner drops req for one cycle.
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h030, '0);
        run_cycle();
        seq[0] = last_gnt;
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h031, '0);
        run_cycle();
        run_cycle();
        req[0] = 1'b0;
        run_cycle();
        seq[1] = last_gnt;
        req[0] = 1'b1;
        lock   = '0;
        run_cycle();
        seq[2] = last_gnt;
        check_eq("drop_own", seq[0], 3'b001);
        check_eq("drop_gap", seq[1], 3'b000);
        check_eq("drop_next", seq[2], 3'b010);
        idle(3);

        // Reset during a locked read burst with reads in flight.
        set_req(2, 1'b1, 1'b1, 1'b0, 12'h005, '0);
        run_cycle();
        run_cycle();
        run_cycle();
        check_eq("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        req   = '1;
        lock  = '0;
        we    = '0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_gnt", gnt, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_outputs();
            check_eq("rst_gnt_hold", gnt, 0);
        end
        rst_n = 1'b1;
        run_cycle();
        check_eq("rst_ptr", last_gnt, 3'b001);
        for (int k = 0; k < 4; k++) run_cycle();
        idle(3);

        // Randomized traffic; each request is held with fixed attributes until granted.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(2) != 0) begin
                    set_req(i, 1'b1, ($urandom_range(9) < 4), ($urandom_range(9) < 3),
                            AW'($urandom_range(15)), DW'($urandom));
                end
            end
            run_cycle();
            for (int i = 0; i < NREQ; i++) if (last_gnt[i]) req[i] = 1'b0;
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
